mipi_vc_mon: RTL and testbench



---
 rtl/mipi_mon_pkg.sv | 12 +
 rtl/mipi_vc_mon_if.sv | 9 +
 rtl/mipi_vc_trk.sv | 91 +++++++++
 rtl/mipi_vc_mon.sv | 73 +++++++
 tb/tb_mipi_vc_mon.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/mipi_mon_pkg.sv
// mipi_mon_pkg: shared FSM state encoding, register offsets and saturating-increment helper for the MIPI VC monitor
package mipi_mon_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_VS = 2'd1, ACTIVE = 2'd2, LOCKED = 2'd3} vc_state_e;
  localparam logic [14:0] OFF_CTRL = 15'd0;
  localparam logic [14:0] OFF_STICKY = 15'd1;
  localparam logic [14:0] OFF_MASK = 15'd2;
  localparam logic [14:0] OFF_STAT = 15'd3;
  localparam logic [14:0] OFF_VC = 15'd4;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    return (v == (32'hFFFF_FFFF >> (32 - w))) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/mipi_vc_mon_if.sv
// mipi_vc_mon_if: MCK register bus (MAD word address, MDI write data, MWE write strobe, MDO read data) with master/slave modports
interface mipi_vc_mon_if;
  logic [14:0] MAD;
  logic [31:0] MDI;
  logic MWE;
  logic [31:0] MDO;
  modport master(output MAD, MDI, MWE, input MDO);
  modport slave(input MAD, MDI, MWE, output MDO);
endinterface

// File: rtl/mipi_vc_trk.sv
// mipi_vc_trk: one VC tracker; ports clk/rst, en_i/clr_i control, vs_i/hs_i syncs, state/lock/frame/lines/stable status, to_o timeout pulse
module mipi_vc_trk
  import mipi_mon_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int LOCK_FRAMES = 2,
  parameter logic [23:0] TIMEOUT = 24'd2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  input  logic vs_i,
  input  logic hs_i,
  output vc_state_e state_o,
  output logic lock_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [CNT_W-1:0] last_lines_o,
  output logic [3:0] stable_o,
  output logic to_o
);
  localparam logic [3:0] LF = 4'(LOCK_FRAMES);
  vc_state_e state_q, state_d;
  logic vs_q, hs_q, lock_q, vs_rise, hs_rise, run, to;
  logic [CNT_W-1:0] line_q, line_d, frame_q, frame_d, last_q, last_d;
  logic [3:0] stable_q, stable_d;
  logic [23:0] wd_q, wd_d;
  assign vs_rise = vs_i & ~vs_q;
  assign hs_rise = hs_i & ~hs_q;
  assign run = (state_q == ACTIVE) || (state_q == LOCKED);
  assign to = en_i && run && !vs_rise && (wd_q == TIMEOUT - 24'd1);
  always_comb begin
    state_d = state_q;
    line_d = line_q;
    frame_d = frame_q;
    last_d = last_q;
    stable_d = stable_q;
    wd_d = (run && !vs_rise) ? wd_q + 24'd1 : '0;
    if (!en_i) state_d = IDLE;
    else if (state_q == IDLE) state_d = WAIT_VS;
    else if (state_q == WAIT_VS) begin
      if (vs_rise) begin
        state_d = ACTIVE;
        line_d = '0;
      end
    end else if (to) begin
      state_d = WAIT_VS;
      stable_d = '0;
    end else if (vs_rise) begin
      last_d = line_q;
      frame_d = CNT_W'(sat_inc(32'(frame_q), CNT_W));
      stable_d = (line_q == last_q && line_q != '0) ? ((stable_q < LF) ? stable_q + 4'd1 : stable_q) : 4'd1;
      line_d = '0;
      state_d = (stable_d >= LF) ? LOCKED : ACTIVE;
    end else if (hs_rise) line_d = CNT_W'(sat_inc(32'(line_q), CNT_W));
    if (clr_i) begin
      line_d = '0;
      frame_d = '0;
      last_d = '0;
      stable_d = '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      vs_q <= 1'b0;
      hs_q <= 1'b0;
      lock_q <= 1'b0;
      line_q <= '0;
      frame_q <= '0;
      last_q <= '0;
      stable_q <= '0;
      wd_q <= '0;
    end else begin
      state_q <= state_d;
      vs_q <= vs_i;
      hs_q <= hs_i;
      lock_q <= state_d == LOCKED;
      line_q <= line_d;
      frame_q <= frame_d;
      last_q <= last_d;
      stable_q <= stable_d;
      wd_q <= wd_d;
    end
  assign state_o = state_q;
  assign lock_o = lock_q;
  assign frame_cnt_o = frame_q;
  assign last_lines_o = last_q;
  assign stable_o = stable_q;
  assign to_o = to;
endmodule

// File: rtl/mipi_vc_mon.sv
// mipi_vc_mon: multi-VC MIPI RX monitor; MCK/RST, iVSYNC/iHSYNC/iERROR status in, mb register bus (MDO zero when unaddressed), oVC_LOCK and oERR_IRQ out
module mipi_vc_mon
  import mipi_mon_pkg::*;
#(
  parameter int NUM_VC = 4,
  parameter int ERR_W = 18,
  parameter int CNT_W = 16,
  parameter int LOCK_FRAMES = 2,
  parameter logic [23:0] TIMEOUT = 24'd2000000,
  parameter logic [14:0] BASE_ADDR = 15'h0400
) (
  input  logic MCK,
  input  logic RST,
  input  logic [NUM_VC-1:0] iVSYNC,
  input  logic [NUM_VC-1:0] iHSYNC,
  input  logic [ERR_W-1:0] iERROR,
  mipi_vc_mon_if.slave mb,
  output logic [NUM_VC-1:0] oVC_LOCK,
  output logic oERR_IRQ
);
  localparam int NREG = 4 + 2 * NUM_VC;
  logic [14:0] off;
  logic hit, wr, clr, en_q, unused_mdi;
  logic [ERR_W-1:0] mask_q, sticky_q;
  logic [NUM_VC-1:0] to_q, to_p;
  logic [CNT_W-1:0] evt_q;
  logic [31:0] mdo_q, rdata;
  vc_state_e st [NUM_VC];
  logic [CNT_W-1:0] fc [NUM_VC];
  logic [CNT_W-1:0] ll [NUM_VC];
  logic [3:0] stb [NUM_VC];
  assign off = mb.MAD - BASE_ADDR;
  assign hit = (mb.MAD >= BASE_ADDR) && (off < 15'(NREG));
  assign wr = mb.MWE && hit;
  assign clr = wr && off == OFF_CTRL && mb.MDI[1];
  assign unused_mdi = ^mb.MDI;
  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    mipi_vc_trk #(.CNT_W(CNT_W), .LOCK_FRAMES(LOCK_FRAMES), .TIMEOUT(TIMEOUT)) u_trk (
      .clk(MCK), .rst(RST), .en_i(en_q), .clr_i(clr), .vs_i(iVSYNC[v]), .hs_i(iHSYNC[v]),
      .state_o(st[v]), .lock_o(oVC_LOCK[v]), .frame_cnt_o(fc[v]), .last_lines_o(ll[v]),
      .stable_o(stb[v]), .to_o(to_p[v])
    );
  end
  always_comb begin
    rdata = '0;
    if (hit && off == OFF_CTRL) rdata = 32'(en_q);
    if (hit && off == OFF_STICKY) rdata = 32'(sticky_q);
    if (hit && off == OFF_MASK) rdata = 32'(mask_q);
    if (hit && off == OFF_STAT) rdata = {16'(evt_q), 16'(to_q)};
    for (int v = 0; v < NUM_VC; v++) begin
      if (hit && off == OFF_VC + 15'(2 * v)) rdata = {16'(fc[v]), 16'(ll[v])};
      if (hit && off == OFF_VC + 15'(2 * v + 1)) rdata = {20'b0, stb[v], 3'b0, oVC_LOCK[v], 2'b0, st[v]};
    end
  end
  always_ff @(posedge MCK or posedge RST)
    if (RST) begin
      en_q <= 1'b0;
      mask_q <= '0;
      sticky_q <= '0;
      to_q <= '0;
      evt_q <= '0;
      mdo_q <= '0;
    end else begin
      en_q <= (wr && off == OFF_CTRL) ? mb.MDI[0] : en_q;
      mask_q <= (wr && off == OFF_MASK) ? mb.MDI[ERR_W-1:0] : mask_q;
      sticky_q <= clr ? '0 : (sticky_q & ~((wr && off == OFF_STICKY) ? mb.MDI[ERR_W-1:0] : '0)) | iERROR;
      to_q <= clr ? '0 : (to_q & ~((wr && off == OFF_STAT) ? mb.MDI[NUM_VC-1:0] : '0)) | to_p;
      evt_q <= clr ? '0 : (|iERROR) ? CNT_W'(sat_inc(32'(evt_q), CNT_W)) : evt_q;
      mdo_q <= rdata;
    end
  assign mb.MDO = mdo_q;
  assign oERR_IRQ = |(sticky_q & mask_q);
endmodule

// File: tb/tb_mipi_vc_mon.sv
// tb_mipi_vc_mon: self-checking bench for mipi_vc_mon with directed sequences, register tables and a randomized frame/error model
module tb_mipi_vc_mon;
  localparam int NV = 4;
  localparam logic [14:0] BA = 15'h0400;
  typedef struct {
    logic [14:0] addr;
    logic [31:0] exp;
  } rv_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NV-1:0] vs = '0, hs = '0, lock;
  logic [17:0] err = '0;
  logic irq;
  int checks = 0, errors = 0;
  rv_t tbl [13];
  mipi_vc_mon_if mb ();
  mipi_vc_mon #(.NUM_VC(NV), .ERR_W(18), .CNT_W(16), .LOCK_FRAMES(2), .TIMEOUT(24'd1000), .BASE_ADDR(BA)) dut (
    .MCK(clk), .RST(rst), .iVSYNC(vs), .iHSYNC(hs), .iERROR(err), .mb(mb), .oVC_LOCK(lock), .oERR_IRQ(irq)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic wr(input logic [14:0] a, input logic [31:0] d);
    mb.MAD = a;
    mb.MDI = d;
    mb.MWE = 1'b1;
    tick();
    mb.MWE = 1'b0;
    mb.MAD = 15'h7FFF;
  endtask
  task automatic rdchk(input string nm, input logic [14:0] a, input logic [31:0] exp);
    mb.MAD = a;
    tick();
    chk(nm, mb.MDO, exp);
  endtask
  task automatic hs_pulse(input int v);
    hs[v] = 1'b1;
    tick();
    hs[v] = 1'b0;
    tick();
  endtask
  task automatic vs_pulse(input int v);
    vs[v] = 1'b1;
    tick();
    vs[v] = 1'b0;
    tick();
  endtask
  task automatic frame(input int v, input int n);
    repeat (n) hs_pulse(v);
    vs_pulse(v);
  endtask
  task automatic run_table(input string tag);
    foreach (tbl[i]) rdchk($sformatf("%s_off%0d", tag, i), tbl[i].addr, tbl[i].exp);
  endtask
  task automatic fill_zero();
    foreach (tbl[i]) tbl[i] = '{BA + 15'(i), 32'h0};
  endtask
  initial begin
    int q[$];
    int n, run, stv;
    logic lk;
    logic [17:0] m_sticky, m_mask, e;
    int m_cnt;
    mb.MAD = 15'h7FFF;
    mb.MDI = '0;
    mb.MWE = 1'b0;
    #1;
    chk("rst_mdo", mb.MDO, 0);
    chk("rst_lock", 32'(lock), 0);
    chk("rst_irq", 32'(irq), 0);
    tick();
    rst = 1'b0;
    wr(BA, 32'h1);
    tick(2);
    vs_pulse(0);
    frame(0, 480);
    chk("t1_lock_f1", 32'(lock), 0);
    frame(0, 480);
    chk("t1_lock_f2", 32'(lock), 32'h1);
    frame(0, 480);
    fill_zero();
    tbl[0].exp = 32'h1;
    tbl[4].exp = 32'h0003_01E0;
    tbl[5].exp = 32'h0000_0213;
    tbl[7].exp = 32'h1;
    tbl[9].exp = 32'h1;
    tbl[11].exp = 32'h1;
    run_table("t1");
    chk("t1_lock_vc", 32'(lock), 32'h1);
    repeat (479) hs_pulse(0);
    chk("t2_lock_before", 32'(lock[0]), 1);
    vs[0] = 1'b1;
    tick();
    vs[0] = 1'b0;
    tick();
    chk("t2_lock_drop", 32'(lock[0]), 0);
    rdchk("t2_stat", BA + 15'd5, 32'h0000_0102);
    frame(0, 479);
    chk("t2_relock", 32'(lock[0]), 1);
    rdchk("t2_cnt", BA + 15'd4, 32'h0005_01DF);
    tick(1100);
    chk("t3_lock", 32'(lock[0]), 0);
    rdchk("t3_stat", BA + 15'd5, 32'h0000_0001);
    rdchk("t3_to", BA + 15'd3, 32'h0000_0001);
    wr(BA + 15'd3, 32'h1);
    rdchk("t3_to_w1c", BA + 15'd3, 32'h0);
    rdchk("t3_cnt_hold", BA + 15'd4, 32'h0005_01DF);
    wr(BA + 15'd2, 32'h4);
    repeat (3) begin
      err = 18'h00004;
      tick();
      err = '0;
      tick();
    end
    rdchk("t4_sticky", BA + 15'd1, 32'h4);
    rdchk("t4_evt", BA + 15'd3, 32'h0003_0000);
    chk("t4_irq", 32'(irq), 1);
    err = 18'h00004;
    wr(BA + 15'd1, 32'h4);
    err = '0;
    rdchk("t4_w1c_coinc", BA + 15'd1, 32'h4);
    chk("t4_irq_coinc", 32'(irq), 1);
    wr(BA + 15'd1, 32'h4);
    rdchk("t4_w1c", BA + 15'd1, 32'h0);
    chk("t4_irq_drop", 32'(irq), 0);
    rdchk("t4_evt4", BA + 15'd3, 32'h0004_0000);
    vs_pulse(0);
    repeat (3) hs_pulse(0);
    hs[0] = 1'b1;
    wr(BA, 32'h3);
    hs[0] = 1'b0;
    tick();
    rdchk("t5_cnt", BA + 15'd4, 32'h0);
    rdchk("t5_stat", BA + 15'd5, 32'h0000_0002);
    rdchk("t5_evt", BA + 15'd3, 32'h0);
    rdchk("t5_ctrl", BA, 32'h1);
    rdchk("t5_unmapped", BA + 15'd12, 32'h0);
    rdchk("t5_unrelated", 15'h0000, 32'h0);
    rdchk("t5_below", BA - 15'd1, 32'h0);
    repeat (2) hs_pulse(0);
    vs_pulse(0);
    rdchk("t5_line_clr", BA + 15'd4, 32'h0001_0002);
    vs_pulse(2);
    frame(2, 3);
    frame(2, 3);
    repeat (2) hs_pulse(2);
    err = 18'h00004;
    tick();
    err = '0;
    mb.MAD = BA;
    tick();
    chk("t6_pre_lock", 32'(lock), 32'h4);
    chk("t6_pre_irq", 32'(irq), 1);
    chk("t6_pre_mdo", mb.MDO, 32'h1);
    hs[2] = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("t6_async_lock", 32'(lock), 0);
    chk("t6_async_irq", 32'(irq), 0);
    chk("t6_async_mdo", mb.MDO, 0);
    hs[2] = 1'b0;
    tick();
    rst = 1'b0;
    fill_zero();
    run_table("t6");
    m_sticky = '0;
    m_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      e = ($urandom_range(0, 3) == 0) ? 18'($urandom) : 18'h0;
      err = e;
      m_sticky |= e;
      m_cnt += (e != 0) ? 1 : 0;
      tick();
    end
    err = '0;
    m_mask = 18'($urandom);
    wr(BA + 15'd2, 32'(m_mask));
    rdchk("rnd_sticky", BA + 15'd1, 32'(m_sticky));
    rdchk("rnd_evt", BA + 15'd3, {16'(m_cnt), 16'h0});
    chk("rnd_irq", 32'(irq), 32'(|(m_sticky & m_mask)));
    wr(BA, 32'h1);
    tick(2);
    vs_pulse(1);
    n = 3;
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 2) == 0) n = $urandom_range(0, 5);
      frame(1, n);
      q.push_back(n);
      run = 0;
      for (int i = q.size() - 1; i >= 0 && q[i] == n; i--) run++;
      stv = (n == 0) ? 1 : (run > 2 ? 2 : run);
      lk = stv == 2;
      rdchk($sformatf("rnd_cnt%0d", k), BA + 15'd6, {16'(q.size()), 16'(n)});
      rdchk($sformatf("rnd_stat%0d", k), BA + 15'd7, (32'(stv) << 8) | (32'(lk) << 4) | (lk ? 32'h3 : 32'h2));
      chk($sformatf("rnd_lock%0d", k), 32'(lock), {28'h0, 2'b00, lk, 1'b0});
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
